// File: rtl/ocr_rx_sequencer.sv
// ocr_rx_sequencer
//
// Session controller that walks one license-plate image through the OCR core
// and the OCR_RX_UNIT. A host start clears the RX buffer, issues one OCR start
// per character segment, forwards each segment's valid strobe into the RX unit,
// then holds final_image until the RX unit reports completion.
//
// Parameters
//   MAX_SEGMENTS    max segments per image; larger requests clamp to this
//   SEG_W           width of segment counters; must hold MAX_SEGMENTS
//   GAP_CYCLES      idle cycles between a segment's valid and the next ocr_start (>= 1)
//   TIMEOUT_CYCLES  per-wait watchdog limit in cycles (power of two recommended)
//
// Ports
//   clk_in           single clock, rising edge
//   rst              synchronous active-high reset
//   start            host start pulse, only honoured in IDLE
//   seg_count        segments in the image, sampled with start
//   abort            host abort level, ignored in IDLE
//   ocr_valid        segment-ready strobe from the OCR core
//   rx_done          OCR_RX_done from OCR_RX_UNIT
//   ocr_start        one-cycle start to the OCR core
//   rx_valid_output  ocr_valid gated to the segment-wait state (combinational)
//   rx_clear_buff    Clear_buff pulse to OCR_RX_UNIT
//   rx_final_image   final_image level to OCR_RX_UNIT
//   busy             high in every state except IDLE
//   done             one-cycle session-complete pulse
//   segs_done        segments accepted in the current/last session
//   timeout_err      sticky watchdog error, cleared by the next accepted start
//   stray_err        sticky stray-valid error, cleared by the next accepted start

module ocr_rx_sequencer #(
    parameter int unsigned MAX_SEGMENTS   = 8,
    parameter int unsigned SEG_W          = 4,
    parameter int unsigned GAP_CYCLES     = 10,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             start,
    input  logic [SEG_W-1:0] seg_count,
    input  logic             abort,
    input  logic             ocr_valid,
    input  logic             rx_done,
    output logic             ocr_start,
    output logic             rx_valid_output,
    output logic             rx_clear_buff,
    output logic             rx_final_image,
    output logic             busy,
    output logic             done,
    output logic [SEG_W-1:0] segs_done,
    output logic             timeout_err,
    output logic             stray_err
);

    localparam int unsigned WdW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [WdW-1:0]   WdLast  = WdW'(TIMEOUT_CYCLES - 1);
    localparam logic [GapW-1:0]  GapLast = GapW'(GAP_CYCLES - 1);
    localparam logic [SEG_W-1:0] SegMax  = SEG_W'(MAX_SEGMENTS);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StClearAbort,
        StIssue,
        StWaitSeg,
        StGap,
        StFinal,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [SEG_W-1:0] seg_total_q, seg_total_d;
    logic [SEG_W-1:0] segs_done_q, segs_done_d;
    logic [WdW-1:0]   wd_q, wd_d;
    logic [GapW-1:0]  gap_q, gap_d;
    logic             timeout_err_q, timeout_err_d;
    logic             stray_err_q, stray_err_d;

    logic [SEG_W-1:0] seg_clamped;
    logic [SEG_W-1:0] segs_inc;
    logic             wd_expired;
    logic             abort_hit;

    assign seg_clamped = (seg_count > SegMax) ? SegMax : seg_count;
    assign segs_inc    = segs_done_q + SEG_W'(1);
    assign wd_expired  = (wd_q == WdLast);
    // An abort already being serviced is not re-armed, so a held abort level
    // still yields a single clear pulse before returning to IDLE.
    assign abort_hit   = abort && (state_q != StIdle) && (state_q != StClearAbort);

    // Next-state and counter update
    always_comb begin
        state_d       = state_q;
        seg_total_d   = seg_total_q;
        segs_done_d   = segs_done_q;
        timeout_err_d = timeout_err_q;
        stray_err_d   = stray_err_q;

        // A valid outside the segment wait is never forwarded; flag it.
        if (ocr_valid && (state_q != StWaitSeg)) begin
            stray_err_d = 1'b1;
        end

        if (abort_hit) begin
            state_d = StClearAbort;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        seg_total_d   = seg_clamped;
                        segs_done_d   = '0;
                        timeout_err_d = 1'b0;
                        stray_err_d   = 1'b0;
                        state_d       = (seg_clamped != '0) ? StClear : StFinal;
                    end
                end
                StClear: begin
                    state_d = StIssue;
                end
                StClearAbort: begin
                    state_d = StIdle;
                end
                StIssue: begin
                    state_d = StWaitSeg;
                end
                StWaitSeg: begin
                    if (ocr_valid) begin
                        segs_done_d = segs_inc;
                        state_d     = (segs_inc == seg_total_q) ? StFinal : StGap;
                    end else if (wd_expired) begin
                        // Still flush whatever segments did arrive.
                        timeout_err_d = 1'b1;
                        state_d       = StFinal;
                    end
                end
                StGap: begin
                    if (gap_q == GapLast) begin
                        state_d = StIssue;
                    end
                end
                StFinal: begin
                    if (rx_done) begin
                        state_d = StDone;
                    end else if (wd_expired) begin
                        timeout_err_d = 1'b1;
                        state_d       = StDone;
                    end
                end
                StDone: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // Watchdog restarts on every state change, so it is zero on entry to both
    // WAIT_SEG and FINAL; it saturates rather than wrapping.
    always_comb begin
        wd_d = wd_q;
        if (state_d != state_q) begin
            wd_d = '0;
        end else if (((state_q == StWaitSeg) || (state_q == StFinal)) && !wd_expired) begin
            wd_d = wd_q + WdW'(1);
        end
    end

    // Gap counter runs only while staying in GAP; GAP lasts GAP_CYCLES cycles.
    always_comb begin
        gap_d = '0;
        if ((state_q == StGap) && (state_d == StGap)) begin
            gap_d = gap_q + GapW'(1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q       <= StIdle;
            seg_total_q   <= '0;
            segs_done_q   <= '0;
            wd_q          <= '0;
            gap_q         <= '0;
            timeout_err_q <= 1'b0;
            stray_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            seg_total_q   <= seg_total_d;
            segs_done_q   <= segs_done_d;
            wd_q          <= wd_d;
            gap_q         <= gap_d;
            timeout_err_q <= timeout_err_d;
            stray_err_q   <= stray_err_d;
        end
    end

    // Outputs decoded from registered state; only the valid forward is combinational.
    assign ocr_start       = (state_q == StIssue);
    assign rx_valid_output = ocr_valid && (state_q == StWaitSeg);
    assign rx_clear_buff   = (state_q == StClear) || (state_q == StClearAbort);
    assign rx_final_image  = (state_q == StFinal);
    assign busy            = (state_q != StIdle);
    assign done            = (state_q == StDone);
    assign segs_done       = segs_done_q;
    assign timeout_err     = timeout_err_q;
    assign stray_err       = stray_err_q;

endmodule

// File: doc/ocr_rx_sequencer.md
# ocr_rx_sequencer

Session controller that sequences one license-plate image through the OCR core and OCR_RX_UNIT. On a host start it clears the RX buffer, issues one OCR start per character segment, gates each segment's `valid_output` into the RX unit, then raises `final_image` until `OCR_RX_done`. Sits between the HPS/PIO command path and the OCR core / OCR_RX_UNIT pair. It owns the `Clear_buff`, `valid_output` and `final_image` inputs of OCR_RX_UNIT.

## Interface
- `MAX_SEGMENTS`, 8: max segments per image; larger requests clamp to this.
- `SEG_W`, 4: width of segment counters; must hold `MAX_SEGMENTS`.
- `GAP_CYCLES`, 10: minimum idle cycles between a segment's valid and the next `ocr_start`.
- `TIMEOUT_CYCLES`, 4096: per-wait watchdog limit, in cycles.
- `clk_in`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  host start pulse; sampled only in IDLE.
- `seg_count`  in  SEG_W  segments in this image; sampled with `start`.
- `abort`  in  1  host abort; level, sampled every cycle.
- `ocr_valid`  in  1  segment-ready strobe from the OCR core.
- `rx_done`  in  1  `OCR_RX_done` from OCR_RX_UNIT.
- `ocr_start`  out  1  one-cycle start to the OCR core.
- `rx_valid_output`  out  1  gated `ocr_valid` to OCR_RX_UNIT `valid_output`.
- `rx_clear_buff`  out  1  to OCR_RX_UNIT `Clear_buff`.
- `rx_final_image`  out  1  to OCR_RX_UNIT `final_image`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle session-complete pulse.
- `segs_done`  out  SEG_W  segments accepted this session.
- `timeout_err`  out  1  sticky; cleared by the next accepted `start`.
- `stray_err`  out  1  sticky; cleared by the next accepted `start`.

## Operation
- **Output decode.** All outputs are decoded from registered state and counters. The one exception is `rx_valid_output = ocr_valid & (state==WAIT_SEG)`, which is combinational.
- **Reset.** Resets to IDLE. `segs_done` = 0, both error flags = 0, all strobes = 0.
- **States.** IDLE, CLEAR, ISSUE, WAIT_SEG, GAP, FINAL, DONE.
- **IDLE.**
  - On `start`, latch `seg_total = min(seg_count, MAX_SEGMENTS)`, clear `segs_done` and both error flags.
  - Then go to CLEAR if `seg_total > 0`, else go to FINAL.
  - `start` outside IDLE is ignored.
- **CLEAR.** `rx_clear_buff` = 1 for exactly one cycle, then ISSUE.
- **ISSUE.** `ocr_start` = 1 for one cycle; watchdog cleared; then WAIT_SEG.
- **WAIT_SEG.**
  - On `ocr_valid`: `segs_done++`. If the new `segs_done == seg_total`, go to FINAL; otherwise go to GAP.
  - On watchdog reaching `TIMEOUT_CYCLES-1` with no valid: set `timeout_err` and go to FINAL, so partial results are still flushed.
- **GAP.** Count `GAP_CYCLES`, then ISSUE.
- **FINAL.**
  - `rx_final_image` = 1, held continuously. Watchdog is cleared on entry.
  - On `rx_done`, go to DONE.
  - On watchdog expiry, set `timeout_err` and go to DONE.
- **DONE.** `done` = 1 for one cycle, `rx_final_image` = 0, then IDLE.
- **Stray valids.** `ocr_valid` in any state other than WAIT_SEG is not forwarded and sets `stray_err`.
- **Abort.** `abort` in any non-IDLE state, at highest priority, forces the next state to CLEAR_ABORT.
  - CLEAR_ABORT is an alias of CLEAR that returns to IDLE instead of ISSUE.
  - It pulses `rx_clear_buff` once, then returns to IDLE with no `done` pulse.
  - `abort` in IDLE has no effect.
- **Priority within a cycle.** `rst` > `abort` > `ocr_valid` > watchdog expiry.
- **Watchdog.** SEG_W-independent counter of width `$clog2(TIMEOUT_CYCLES)`; saturates and never wraps.
- **Counter width.** `segs_done` never exceeds `seg_total`.

## Timing
- `start` sampled at edge k:
  - `rx_clear_buff` high in cycle k+1.
  - `ocr_start` high in cycle k+2.
- `ocr_valid` in WAIT_SEG in cycle m:
  - `rx_valid_output` is high in the same cycle m.
  - `segs_done` updates at edge m+1.
- Spacing after a non-last segment: GAP occupies exactly `GAP_CYCLES` cycles, so the next `ocr_start` is `GAP_CYCLES+1` cycles after the valid.
- Last segment valid in cycle m: `rx_final_image` rises in cycle m+1 and stays high through the cycle in which `rx_done` is seen.
- `rx_done` in cycle n: `done` pulses in cycle n+1, and `busy` falls in cycle n+2.
- Back-to-back sessions: `start` is accepted in the first IDLE cycle (n+2).
- `rst` asserted mid-session: at the next edge all outputs return to reset values, and `rx_final_image` drops that edge.

## Test plan
- **Normal 3-segment image.** `seg_count`=3; core answers each `ocr_start` with `ocr_valid` after 5 cycles; `rx_done` arrives 4 cycles after final rises.
  - Required: exactly 1 `rx_clear_buff`, 3 `ocr_start`, 3 `rx_valid_output`; starts spaced per GAP.
  - Required: `segs_done`=3, one `done`, both error flags 0.
- **Clamp.** `seg_count`=12 with `MAX_SEGMENTS`=8 → exactly 8 `ocr_start`, then `rx_final_image`; `segs_done`=8.
- **Segment timeout.** `seg_count`=2; core never answers the second start.
  - Required: after 4096 cycles `timeout_err`=1 and `rx_final_image` rises.
  - Required: `done` pulses after `rx_done`; `segs_done`=1.
- **Abort mid-session.** `abort` asserted during GAP of segment 1 → one `rx_clear_buff` pulse, return to IDLE, `busy`=0, no `done`; a new `start` is then accepted.
- **Stray valid and ignored start.** `ocr_valid` during GAP → not forwarded, `stray_err`=1. `start` during WAIT_SEG → no effect. Next accepted `start` clears `stray_err`.
- **Zero segments and reset.**
  - `seg_count`=0 → no clear, no `ocr_start`, `rx_final_image` immediately; `done` follows `rx_done`.
  - `rst` during FINAL → all outputs 0 at the next edge.
